// File: rtl/serial_chunk_adder.sv
// Chunk-loaded add/subtract unit: operands loaded CHUNK bits per button press,
// result computed bit-serially (one bit per clock) and held for display.
module serial_chunk_adder #(
   parameter int WIDTH       = 7,
   parameter int CHUNK       = 4,
   parameter int SYNC_STAGES = 2,
   localparam int NCHUNK     = (WIDTH + CHUNK - 1) / CHUNK,
   localparam int PW         = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pb_x,
   input  logic             pb_y,
   input  logic             pb_go,
   input  logic             sub,
   input  logic [CHUNK-1:0] a,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic             done,
   output logic [PW-1:0]    chunk_x,
   output logic [PW-1:0]    chunk_y
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_x, sync_y, sync_go;
   logic                   prev_x, prev_y, prev_go;
   logic                   ev_x, ev_y, ev_go;
   logic [WIDTH-1:0]       x, y, x_load, y_load;
   logic [WIDTH-1:0]       xs, ys;
   logic [WIDTH-2:0]       r;
   logic [WIDTH-1:0]       r_next;
   logic                   c, bit_s, c_next;
   logic [CW-1:0]          cnt;

   // Sync and prev flops reset high so a button held through reset stays silent.
   assign ev_x  = sync_x[SYNC_STAGES-1]  & ~prev_x;
   assign ev_y  = sync_y[SYNC_STAGES-1]  & ~prev_y;
   assign ev_go = sync_go[SYNC_STAGES-1] & ~prev_go;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(NCHUNK - 1)) ? '0 : p + 1'b1;
   endfunction

   // Bits of a beyond the top of the last chunk never map to an operand bit.
   always_comb begin
      x_load = x;
      y_load = y;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (chunk_x == PW'(i / CHUNK)) x_load[i] = a[i % CHUNK];
         if (chunk_y == PW'(i / CHUNK)) y_load[i] = a[i % CHUNK];
      end
   end

   always_comb begin
      bit_s  = xs[0] ^ ys[0] ^ c;
      c_next = (xs[0] & ys[0]) | (c & (xs[0] ^ ys[0]));
      r_next = {bit_s, r};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sync_x  <= '1;
         sync_y  <= '1;
         sync_go <= '1;
         prev_x  <= 1'b1;
         prev_y  <= 1'b1;
         prev_go <= 1'b1;
         x       <= '0;
         y       <= '0;
         xs      <= '0;
         ys      <= '0;
         r       <= '0;
         c       <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         chunk_x <= '0;
         chunk_y <= '0;
      end else begin
         sync_x  <= {sync_x[SYNC_STAGES-2:0], pb_x};
         sync_y  <= {sync_y[SYNC_STAGES-2:0], pb_y};
         sync_go <= {sync_go[SYNC_STAGES-2:0], pb_go};
         prev_x  <= sync_x[SYNC_STAGES-1];
         prev_y  <= sync_y[SYNC_STAGES-1];
         prev_go <= sync_go[SYNC_STAGES-1];

         if (state != CALC) begin
            if (ev_x) begin
               x       <= x_load;
               chunk_x <= bump(chunk_x);
            end
            if (ev_y) begin
               y       <= y_load;
               chunk_y <= bump(chunk_y);
            end
         end

         case (state)
            IDLE, DONE: begin
               if (ev_go) begin
                  xs    <= x;
                  ys    <= sub ? ~y : y;
                  c     <= sub;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  state <= CALC;
               end
            end
            CALC: begin
               xs  <= xs >> 1;
               ys  <= ys >> 1;
               r   <= r_next[WIDTH-1:1];
               c   <= c_next;
               cnt <= cnt + 1'b1;
               // On the last bit, c is still the carry into the MSB.
               if (cnt == CW'(WIDTH - 1)) begin
                  sum   <= r_next;
                  cout  <= c_next;
                  ovf   <= c ^ c_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: a 7-bit and a 16-bit instance, expected
// results queued at go and checked when done is reached.
module tb_serial_chunk_adder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  pbx = '0, pby = '0, pbg = '0;
   logic        sub = 1'b0;
   logic [3:0]  a = '0;
   logic [6:0]  sum7;
   logic [15:0] sum16;
   logic [1:0]  cout, ovf, busy, done;
   logic [0:0]  chunk_x7, chunk_y7;
   logic [1:0]  chunk_x16, chunk_y16;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] s;
      logic        co;
      logic        ov;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   serial_chunk_adder #(.WIDTH(7), .CHUNK(4), .SYNC_STAGES(2)) u7 (
      .clk(clk), .rst(rst), .pb_x(pbx[0]), .pb_y(pby[0]), .pb_go(pbg[0]),
      .sub(sub), .a(a), .sum(sum7), .cout(cout[0]), .ovf(ovf[0]),
      .busy(busy[0]), .done(done[0]), .chunk_x(chunk_x7), .chunk_y(chunk_y7)
   );

   serial_chunk_adder #(.WIDTH(16), .CHUNK(4), .SYNC_STAGES(2)) u16 (
      .clk(clk), .rst(rst), .pb_x(pbx[1]), .pb_y(pby[1]), .pb_go(pbg[1]),
      .sub(sub), .a(a), .sum(sum16), .cout(cout[1]), .ovf(ovf[1]),
      .busy(busy[1]), .done(done[1]), .chunk_x(chunk_x16), .chunk_y(chunk_y16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sum_of(input int d);
      return (d == 1) ? sum16 : {9'b0, sum7};
   endfunction

   task automatic press(input int d, input int which, input logic [3:0] v);
      a = v;
      if (which == 0) pbx[d] = 1'b1; else pby[d] = 1'b1;
      repeat (4) @(negedge clk);
      if (which == 0) pbx[d] = 1'b0; else pby[d] = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic run_op(input int d, input logic s, input logic [15:0] es,
                         input logic eco, input logic eov, input int w, input bit inj);
      exp_t        e;
      logic [15:0] prev_sum;
      int          n;
      q.push_back('{s: es, co: eco, ov: eov});
      prev_sum = sum_of(d);
      sub = s;
      pbg[d] = 1'b1;
      n = 0;
      while (!busy[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("busy_rise", 32'(busy[d]), 32'd1);
      pbg[d] = 1'b0;
      chk("done_low_in_calc", 32'(done[d]), 32'd0);
      chk("sum_held_in_calc", 32'(sum_of(d)), 32'(prev_sum));
      if (inj) a = 4'hF;
      n = 0;
      while (busy[d] && n < 40) begin
         if (inj && n == 1) pby[d] = 1'b1;
         if (inj && n == 4) pby[d] = 1'b0;
         @(negedge clk);
         n++;
      end
      pby[d] = 1'b0;
      chk("busy_cycles", 32'(n), 32'(w));
      chk("done_high", 32'(done[d]), 32'd1);
      e = q.pop_front();
      chk("sum", 32'(sum_of(d)), 32'(e.s));
      chk("cout", 32'(cout[d]), 32'(e.co));
      chk("ovf", 32'(ovf[d]), 32'(e.ov));
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_sum7", 32'(sum7), 32'd0);
      chk("rst_sum16", 32'(sum16), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
      chk("rst_chunk7", 32'({chunk_x7, chunk_y7}), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // 0x55 + 0x2A
      press(0, 0, 4'h5); press(0, 0, 4'h5);
      press(0, 1, 4'hA); press(0, 1, 4'h2);
      chk("ptr_after_two_x", 32'(chunk_x7), 32'd0);
      chk("ptr_after_two_y", 32'(chunk_y7), 32'd0);
      run_op(0, 1'b0, 16'h007F, 1'b0, 1'b0, 7, 1'b0);

      // 0x7F + 0x01 wraps to zero with carry
      press(0, 0, 4'hF); press(0, 0, 4'h7);
      press(0, 1, 4'h1); press(0, 1, 4'h0);
      run_op(0, 1'b0, 16'h0000, 1'b1, 1'b0, 7, 1'b0);

      // 0x05 - 0x09 borrows
      press(0, 0, 4'h5); press(0, 0, 4'h0);
      press(0, 1, 4'h9); press(0, 1, 4'h0);
      run_op(0, 1'b1, 16'h007C, 1'b0, 1'b0, 7, 1'b0);

      // 0x3F + 0x01 signed overflow
      press(0, 0, 4'hF); press(0, 0, 4'h3);
      press(0, 1, 4'h1); press(0, 1, 4'h0);
      run_op(0, 1'b0, 16'h0040, 1'b0, 1'b1, 7, 1'b0);

      // Pointer wrap: chunks 0,1,0 get 1,2,3 -> X=0x23; Y chunk0=2 -> Y=0x02
      press(0, 0, 4'h1); press(0, 0, 4'h2); press(0, 0, 4'h3);
      chk("ptr_wrap_x", 32'(chunk_x7), 32'd1);
      press(0, 1, 4'h2);
      chk("ptr_y", 32'(chunk_y7), 32'd1);
      run_op(0, 1'b0, 16'h0025, 1'b0, 1'b0, 7, 1'b1);
      chk("ptr_y_after_calc_press", 32'(chunk_y7), 32'd1);
      run_op(0, 1'b0, 16'h0025, 1'b0, 1'b0, 7, 1'b0);

      // Reset in the third CALC cycle with go held through reset
      pbg[0] = 1'b1;
      n = 0;
      while (!busy[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("abort_busy_rise", 32'(busy[0]), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_sum", 32'(sum7), 32'd0);
      chk("abort_flags", 32'({cout[0], ovf[0], busy[0], done[0]}), 32'd0);
      chk("abort_ptrs", 32'({chunk_x7, chunk_y7}), 32'd0);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy[0] || done[0]) n++;
      end
      chk("held_go_silent", 32'(n), 32'd0);
      pbg[0] = 1'b0;
      repeat (3) @(negedge clk);
      press(0, 0, 4'h3);
      run_op(0, 1'b0, 16'h0003, 1'b0, 1'b0, 7, 1'b0);

      // 16-bit instance: 0xFFFF + 0x0001, then 0xFFFF - 0x0001
      for (int i = 0; i < 4; i++) press(1, 0, 4'hF);
      press(1, 1, 4'h1);
      for (int i = 0; i < 3; i++) press(1, 1, 4'h0);
      chk("ptr16_wrap", 32'({chunk_x16, chunk_y16}), 32'd0);
      run_op(1, 1'b0, 16'h0000, 1'b1, 1'b0, 16, 1'b0);
      run_op(1, 1'b1, 16'hFFFE, 1'b1, 1'b0, 16, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
